// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//
// Shared definitions for the Lab08 timer blocks.
//
// Contents:
//   TIMER_WIDTH    default counter / load width
//   timer_state_t  2-bit state type for the down-timer FSM
//   ST_IDLE        counter parked, waiting for a non-zero load
//   ST_RUN         counting down on enabled cycles
//   ST_DONE        one-shot finished, counter parked at zero
//
// Encoding 2'd3 is unused. The FSM treats it as illegal and recovers to
// ST_IDLE.
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam int TIMER_WIDTH = 12;

    typedef logic [1:0] timer_state_t;

    localparam timer_state_t ST_IDLE = 2'd0;
    localparam timer_state_t ST_RUN  = 2'd1;
    localparam timer_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/timer12_down.sv
// ---------------------------------------------------------------------------
// timer12_down
//
// Loadable down-counter / timer with terminal-count detection. This is the
// count-down companion of cont12 and uses the same enable / loact / load
// control style. A non-zero preload starts the count. The counter then
// decrements on enabled cycles. When an enabled edge meets a count of 1,
// the block raises a one-cycle tc pulse and then does one of two things:
//   - one-shot (auto_reload = 0): parks at 0 in DONE;
//   - periodic (auto_reload = 1): reloads the last preload value.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   enable       in   decrement permission, honoured only in RUN
//   loact        in   load strobe; writes load into counter and reload reg
//   load         in   [WIDTH-1:0] preload value
//   auto_reload  in   1 = periodic, 0 = one-shot (looked at on terminal edge)
//   cont         out  [WIDTH-1:0] registered current count
//   tc           out  registered terminal-count pulse, one cycle wide
//   busy         out  high while in RUN
//   done         out  sticky one-shot completion flag, high in DONE
//
// Edge priority: reset > loact > enable.
// ---------------------------------------------------------------------------
module timer12_down
    import timer_pkg::*;
#(
    parameter int WIDTH = timer_pkg::TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             loact,
    input  logic [WIDTH-1:0] load,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] cont,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] cont_q,  cont_d;
    logic [WIDTH-1:0] rld_q,   rld_d;
    logic             tc_q,    tc_d;

    // Next-value decode.
    // A load always wins over counting, so a terminal count that lands on
    // the same edge as a load is dropped. tc defaults to 0 on every cycle,
    // which keeps the pulse one cycle wide without extra edge detection.
    // A count of 1 on an enabled edge is the terminal edge. A count of 0
    // can only appear in RUN through a corrupted state. That case parks
    // in IDLE instead of wrapping to all-ones.
    always_comb begin
        state_d = state_q;
        cont_d  = cont_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;

        if (loact) begin
            cont_d  = load;
            rld_d   = load;
            state_d = (load != ZERO) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (enable) begin
                        if (cont_q == ONE) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                cont_d  = rld_q;
                                state_d = ST_RUN;
                            end else begin
                                cont_d  = ZERO;
                                state_d = ST_DONE;
                            end
                        end else if (cont_q == ZERO) begin
                            state_d = ST_IDLE;
                        end else begin
                            cont_d = cont_q - ONE;
                        end
                    end
                end
                ST_DONE: begin
                    cont_d  = ZERO;
                    state_d = ST_DONE;
                end
                default: begin
                    cont_d  = ZERO;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, reload value and tc all update together on the clock.
    // Reset clears the reload register as well. A periodic timer that has
    // been reset must be loaded again before it can run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cont_q  <= ZERO;
            rld_q   <= ZERO;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cont_q  <= cont_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
        end
    end

    // Status outputs are decoded straight from the registered state, so
    // they have no path from the inputs.
    assign cont = cont_q;
    assign tc   = tc_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_timer12_down.sv
// ---------------------------------------------------------------------------
// tb_timer12_down
//
// Directed self-checking bench for timer12_down. Inputs change on the
// falling edge. The following falling edge samples the outputs, after the
// rising edge has consumed those inputs. All expected values are worked
// out by hand from the timer behaviour.
// ---------------------------------------------------------------------------
module tb_timer12_down;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        loact;
    logic [11:0] load;
    logic        auto_reload;
    logic [11:0] cont;
    logic        tc;
    logic        busy;
    logic        done;

    int checkCount;
    int errorCount;
    int tcPulses;

    timer12_down dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .loact       (loact),
        .load        (load),
        .auto_reload (auto_reload),
        .cont        (cont),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then wait until the outputs for that edge
    // have settled.
    task automatic applyStimulus(input logic rst, input logic la,
                                 input logic [11:0] ld, input logic en,
                                 input logic ar);
        reset       = rst;
        loact       = la;
        load        = ld;
        enable      = en;
        auto_reload = ar;
        @(negedge clk);
    endtask

    // Single comparison point used by every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Checks all four outputs at once.
    task automatic checkAll(input string tag, input logic [11:0] expCont,
                            input logic expTc, input logic expBusy,
                            input logic expDone);
        checkOutput({tag, ".cont"}, 32'(cont), 32'(expCont));
        checkOutput({tag, ".tc"},   32'(tc),   32'(expTc));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
        checkOutput({tag, ".done"}, 32'(done), 32'(expDone));
    endtask

    initial begin
        logic [11:0] gateCont [6];
        logic        gateEn   [6];
        logic [11:0] expCont;
        logic        expTc;

        checkCount  = 0;
        errorCount  = 0;
        reset       = 1'b0;
        loact       = 1'b0;
        load        = '0;
        enable      = 1'b0;
        auto_reload = 1'b0;
        @(negedge clk);

        // Reset hold: a pending load must not get through while reset is high.
        $display("[TB] reset hold");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 12'h123, 1'b1, 1'b0);
            checkAll("reset_hold", 12'h000, 1'b0, 1'b0, 1'b0);
        end

        // One-shot count from 5.
        $display("[TB] one-shot");
        applyStimulus(1'b0, 1'b1, 12'h005, 1'b1, 1'b0);
        checkAll("oneshot_load", 12'h005, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
            checkAll("oneshot_dec", 12'(5 - k), 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        checkAll("oneshot_term", 12'h000, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
            checkAll("oneshot_hold", 12'h000, 1'b0, 1'b0, 1'b1);
        end

        // Periodic count from 3, with 12 enabled cycles after the load.
        $display("[TB] periodic");
        applyStimulus(1'b0, 1'b1, 12'h003, 1'b1, 1'b1);
        checkAll("periodic_load", 12'h003, 1'b0, 1'b1, 1'b0);
        tcPulses = 0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
            expCont = (k % 3 == 0) ? 12'h003 : 12'(3 - (k % 3));
            expTc   = (k % 3 == 0);
            if (tc) tcPulses++;
            checkAll("periodic_run", expCont, expTc, 1'b1, 1'b0);
        end
        checkOutput("periodic_pulses", 32'(tcPulses), 32'd4);

        // Enable gating from 4: the count is 4,3,3,3,2,1,0.
        $display("[TB] enable gating");
        gateEn   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        gateCont = '{12'h003, 12'h003, 12'h003, 12'h002, 12'h001, 12'h000};
        applyStimulus(1'b0, 1'b1, 12'h004, 1'b0, 1'b0);
        checkAll("gate_load", 12'h004, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 12'h000, gateEn[k], 1'b0);
            if (k == 5) checkAll("gate_term", gateCont[k], 1'b1, 1'b0, 1'b1);
            else        checkAll("gate_step", gateCont[k], 1'b0, 1'b1, 1'b0);
        end

        // Load collision: a load on the would-be terminal edge wins and tc stays 0.
        $display("[TB] load collision and zero load");
        applyStimulus(1'b0, 1'b1, 12'h002, 1'b0, 1'b0);
        checkAll("coll_load", 12'h002, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        checkAll("coll_one", 12'h001, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 12'h7C7, 1'b1, 1'b0);
        checkAll("coll_hit", 12'h7C7, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        checkAll("coll_after", 12'h7C6, 1'b0, 1'b1, 1'b0);

        // A zero load lands in IDLE, and enable is then ignored.
        applyStimulus(1'b0, 1'b1, 12'h000, 1'b1, 1'b1);
        checkAll("zero_load", 12'h000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
            checkAll("zero_idle", 12'h000, 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-run: load 0xFFF, count 20 cycles, then reset.
        $display("[TB] reset mid-run");
        applyStimulus(1'b0, 1'b1, 12'hFFF, 1'b0, 1'b1);
        checkAll("max_load", 12'hFFF, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
        end
        checkAll("max_count20", 12'hFEB, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b1, 1'b1);
        checkAll("midrun_reset", 12'h000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
            checkAll("post_reset", 12'h000, 1'b0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/timer12_down.md
# timer12_down

Loadable 12-bit down-counter/timer with terminal-count detection: the count-down counterpart of the existing 12-bit up-counter (`cont12`), sharing its control style (`enable`, `loact`, `load`). It is preloaded with a value, decrements on enabled cycles, and signals terminal count. It then either stops (one-shot) or reloads itself (periodic). It sits beside `cont12` in the Lab08 datapath as the delay/period generator that gates other blocks.

## Interface
- `WIDTH`, 12, counter and load width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset; one clock only.
- `enable`  in  1  decrement permission; sampled every rising edge.
- `loact`  in  1  load strobe; `load` is written into the counter and the reload register.
- `load`  in  WIDTH  preload value.
- `auto_reload`  in  1  1 = periodic mode, 0 = one-shot mode; sampled at the terminal-count edge.
- `cont`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal-count pulse, registered, high for exactly one cycle.
- `busy`  out  1  high while the state is RUN.
- `done`  out  1  sticky one-shot completion flag; high in state DONE.

## Operation
- Priority at each edge: `reset` > `loact` > `enable`.
- Internal reload register `rld` (WIDTH bits).
- States are IDLE, RUN and DONE.
- Reset: state IDLE, `cont`=0, `rld`=0, `tc`=0, `busy`=0, `done`=0.
- `loact`=1, in any state:
  - `cont`←`load` and `rld`←`load`.
  - Next state is RUN if `load`≠0, otherwise IDLE.
  - `tc` is 0 that cycle; `done` is cleared.
  - An in-flight terminal count is discarded, even if `cont`==1 and `enable`=1 on the same edge.
- IDLE: holds `cont`; `enable` is ignored.
- RUN, `enable`=0: hold.
- RUN, `enable`=1, `cont`>1: `cont`←`cont`−1.
- RUN, `enable`=1, `cont`==1 (terminal edge):
  - `tc`←1.
  - If `auto_reload`=1: `cont`←`rld` and stay in RUN.
  - If `auto_reload`=0: `cont`←0 and go to DONE.
- DONE: `cont` holds 0 and `done`=1 until `loact` or `reset`; `enable` is ignored.
- Arithmetic is unsigned. `cont` never decrements below 0 and never wraps to 0xFFF.
- Counting from 0 is impossible because a load of 0 lands in IDLE.
- Maximum load 0xFFF gives 4095 enabled cycles to terminal count.
- `auto_reload` changes mid-count take effect only at the next terminal edge.

## Timing
- All outputs are registered and change only on rising `clk`; there are no combinational input-to-output paths.
- Load latency: `cont` shows `load` one edge after `loact` is sampled.
- One-shot: after loading N, `tc`=1 is visible in the cycle following the N-th enabled edge, the same cycle in which `cont` first shows 0.
- Periodic: `tc` repeats every N enabled cycles. `cont` sequence: N, N−1, …, 1, N, …; the value 0 is never shown.
- `tc` is high for 1 cycle even if `enable` stays high. It drops on the next edge regardless of inputs.
- `busy` = (state==RUN), `done` = (state==DONE), both decoded from registered state.
- Reset mid-count: all outputs are zero one edge later and the `rld` contents are lost.

## Structure
- Shared package `timer_pkg`:
  - `WIDTH` default.
  - State typedef `timer_state_t` with encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - 2'd3 is illegal and recovers to IDLE.
- Single module. The next-state/counter logic is one clocked process plus a combinational next-value decode.
- No sub-module is required. The equality-to-1 terminal detect stays inline.

## Test plan
- Reset hold: `reset`=1 for 2 cycles with `loact`=1 and `load`=0x123 → `cont`=0, `busy`=0, `tc`=0, `done`=0 throughout.
- One-shot count:
  - Stimulus: load 0x005, `auto_reload`=0, `enable`=1.
  - Required `cont`: 5,4,3,2,1,0.
  - `tc` high exactly in the cycle `cont`=0; then `done`=1 and `busy`=0.
  - `cont` stays 0 for 10 further cycles.
- Periodic: load 0x003, `auto_reload`=1, `enable`=1 for 12 cycles → `cont` 3,2,1,3,2,1,…; `tc` pulses on every reload, 4 pulses total.
- Enable gating: load 0x004, pattern `enable`=1,0,0,1,1,1 → `cont` 4,3,3,3,2,1,0; `tc` pulses once at the 0.
- Load collision and zero load:
  - `loact`=1 with `load`=0x7C7 on the same edge as a would-be terminal count (`cont`=1, `enable`=1) → `cont`=0x7C7, `tc` stays 0, state RUN.
  - Loading 0x000 → IDLE, `busy`=0, no `tc`.
- Reset mid-run: load 0xFFF, count 20 cycles to 0xFEB, then assert `reset` → next edge `cont`=0 and state IDLE; a subsequent `enable` without a load leaves `cont` at 0.
